spart_rx: RTL and testbench

Receive stage of the SPART. Consumes the asynchronous `rxd` pin through a 2-flop synchronizer and deserializes 8N1 frames using a 16x oversampling tick from the baud-rate generator. Presents the received byte, the `rda` flag and error flags to the SPART bus interface, which drives them onto `databus` when the driver reads the receive buffer.

---
 rtl/spart_pkg.sv | 19 +
 rtl/spart_rx_sync2.sv | 27 ++
 rtl/spart_rx.sv | 163 ++++++++++++++++
 tb/tb_spart_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states, oversampling defaults and bus addresses.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int         OVERSAMPLE_DEF = 16;
    localparam int         MID_TICK       = OVERSAMPLE_DEF / 2 - 1;
    localparam logic [1:0] RX_ADDR        = 2'b00;

    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/spart_rx_sync2.sv
// Generic two-flop synchronizer for asynchronous pin inputs, with a configurable reset level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: synchronizes rxd and deserializes 8N1 frames on oversample ticks.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam logic [3:0] MID_CNT  = 4'(mid_tick(OVERSAMPLE));
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

    logic       rxs_s;
    logic       load_s;
    logic [3:0] cnt_inc_s;

    rx_state_t  state_q,   state_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [2:0] bidx_q,    bidx_d;
    logic [7:0] shreg_q,   shreg_d;
    logic       prev_q,    prev_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rda_q,     rda_d;
    logic       frm_q,     frm_d;
    logic       ovr_q,     ovr_d;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync_rxd (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (rxd),
        .q_o   (rxs_s)
    );

    assign cnt_inc_s = cnt_q + 4'd1;

    // Frame FSM: advances only on oversample ticks
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        prev_d  = prev_q;
        load_s  = 1'b0;
        if (en) begin
            // prev tracks the line in every state so a held-low line never looks like a new edge
            prev_d = rxs_s;
            case (state_q)
                IDLE: begin
                    if (prev_q && !rxs_s) begin
                        state_d = START;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (cnt_inc_s == MID_CNT) begin
                        if (!rxs_s) begin
                            state_d = DATA;
                            cnt_d   = 4'd0;
                            bidx_d  = 3'd0;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        shreg_d = {rxs_s, shreg_q[7:1]};
                        cnt_d   = 4'd0;
                        bidx_d  = bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        load_s  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receive buffer and flags; a load in the same cycle as rd_ack takes priority
    always_comb begin
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        frm_d     = frm_q;
        ovr_d     = ovr_q;
        if (load_s) begin
            rx_data_d = shreg_q;
            rda_d     = 1'b1;
            frm_d     = ~rxs_s;
            ovr_d     = rda_q & ~rd_ack;
        end else if (rd_ack) begin
            rda_d = 1'b0;
            frm_d = 1'b0;
            ovr_d = 1'b0;
        end else begin
            rda_d = rda_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            bidx_q    <= 3'd0;
            shreg_q   <= 8'h00;
            prev_q    <= 1'b1;
            rx_data_q <= 8'h00;
            rda_q     <= 1'b0;
            frm_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bidx_q    <= bidx_d;
            shreg_q   <= shreg_d;
            prev_q    <= prev_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            frm_q     <= frm_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rda     = rda_q;
    assign frm_err = frm_q;
    assign ovr_err = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: directed scenarios plus random frames against a tick-history model.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rxd;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rda;
    logic       frm_err;
    logic       ovr_err;

    always #5 clk = ~clk;

    spart_rx #(.OVERSAMPLE(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .rxd     (rxd),
        .rd_ack  (rd_ack),
        .rx_data (rx_data),
        .rda     (rda),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: line level seen at every tick since reset
    logic       hist[$];
    int         t0;
    logic [7:0] m_data;
    logic       m_rda, m_frm, m_ovr;
    bit         auto_ack;
    bit         ack_on_load;
    logic [7:0] dut_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        t0     = -1;
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_frm  = 1'b0;
        m_ovr  = 1'b0;
    endfunction

    function automatic bit load_due();
        return (t0 >= 0) && (hist.size() == t0 + 151);
    endfunction

    function automatic void model_clear();
        m_rda = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
    endfunction

    // A frame starts on the first low tick after a high one; start checked 7 ticks later,
    // data bit k at t0+23+16k, stop and load at t0+151.
    function automatic void model_tick(input logic lvl, input logic ack);
        int         n;
        logic       pl;
        logic [7:0] b;
        bit         ld;
        ld = 1'b0;
        b  = 8'h00;
        hist.push_back(lvl);
        n  = hist.size() - 1;
        pl = (n == 0) ? 1'b1 : hist[n-1];
        if (t0 >= 0) begin
            if (n == t0 + 7 && lvl == 1'b1) begin
                t0 = -1;
            end else if (n == t0 + 151) begin
                for (int k = 0; k < 8; k++) b[k] = hist[t0 + 23 + 16*k];
                ld = 1'b1;
                t0 = -1;
            end
        end else if (pl == 1'b1 && lvl == 1'b0) begin
            t0 = n;
        end
        if (ld) begin
            m_ovr  = m_rda & ~ack;
            m_rda  = 1'b1;
            m_frm  = ~lvl;
            m_data = b;
        end else if (ack) begin
            model_clear();
        end
    endfunction

    task automatic compare_outputs(input string where);
        check_eq({where, "_rda"},     rda,     m_rda);
        check_eq({where, "_rx_data"}, rx_data, m_data);
        check_eq({where, "_frm_err"}, frm_err, m_frm);
        check_eq({where, "_ovr_err"}, ovr_err, m_ovr);
    endtask

    // One oversample tick spread over 4 clk: line set, three idle cycles, then en
    task automatic do_tick(input logic lvl, input bit force_ack);
        bit   ack_e;
        bit   ack_t;
        logic was_rda;
        ack_e  = force_ack || (auto_ack && m_rda);
        ack_t  = ack_on_load && load_due();
        rxd    = lvl;
        rd_ack = ack_e;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        if (ack_e) begin
            model_clear();
            compare_outputs("ack");
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        was_rda = rda;
        en      = 1'b1;
        rd_ack  = ack_t;
        @(posedge clk); #1;
        en      = 1'b0;
        rd_ack  = 1'b0;
        model_tick(lvl, ack_t);
        compare_outputs("tick");
        if (rda && !was_rda) dut_q.push_back(rx_data);
    endtask

    task automatic idle(input int n, input logic lvl);
        for (int i = 0; i < n; i++) do_tick(lvl, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int nticks);
        logic lvl;
        for (int i = 0; i < nticks; i++) begin
            if (i < 16)       lvl = 1'b0;
            else if (i < 144) lvl = b[(i - 16) / 16];
            else              lvl = stop;
            do_tick(lvl, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         gap;

        rst = 1'b0; en = 1'b0; rxd = 1'b1; rd_ack = 1'b0;
        auto_ack = 1'b0; ack_on_load = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(20, 1'b1);

        // Nominal frame
        send_frame(8'h55, 1'b1, 160);
        check_eq("nom_rda", rda, 1'b1);
        check_eq("nom_data", rx_data, 8'h55);
        check_eq("nom_frm", frm_err, 1'b0);
        check_eq("nom_ovr", ovr_err, 1'b0);
        do_tick(1'b1, 1'b1);
        check_eq("nom_ack_rda", rda, 1'b0);
        check_eq("nom_ack_data", rx_data, 8'h55);

        // Glitch rejection
        idle(3, 1'b0);
        idle(20, 1'b1);
        check_eq("glitch_rda", rda, 1'b0);
        send_frame(8'h3C, 1'b1, 160);
        check_eq("glitch_next_data", rx_data, 8'h3C);
        check_eq("glitch_next_rda", rda, 1'b1);
        do_tick(1'b1, 1'b1);

        // Framing error followed by break
        send_frame(8'hA3, 1'b0, 160);
        check_eq("frm_data", rx_data, 8'hA3);
        check_eq("frm_rda", rda, 1'b1);
        check_eq("frm_flag", frm_err, 1'b1);
        do_tick(1'b0, 1'b1);
        idle(39, 1'b0);
        check_eq("break_rda", rda, 1'b0);
        idle(10, 1'b1);

        // Overrun, then overrun avoided by ack on the load cycle
        send_frame(8'h11, 1'b1, 160);
        send_frame(8'h22, 1'b1, 160);
        check_eq("ovr_data", rx_data, 8'h22);
        check_eq("ovr_flag", ovr_err, 1'b1);
        do_tick(1'b1, 1'b1);
        send_frame(8'h11, 1'b1, 160);
        ack_on_load = 1'b1;
        send_frame(8'h22, 1'b1, 160);
        ack_on_load = 1'b0;
        check_eq("ovr_ackload_flag", ovr_err, 1'b0);
        check_eq("ovr_ackload_rda", rda, 1'b1);
        check_eq("ovr_ackload_data", rx_data, 8'h22);

        // Reset in the middle of bit 4 of 0xF0
        send_frame(8'hF0, 1'b1, 16 + 16*4 + 8);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        compare_outputs("async_reset");
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(10, 1'b1);
        send_frame(8'h81, 1'b1, 160);
        check_eq("post_reset_data", rx_data, 8'h81);
        check_eq("post_reset_frm", frm_err, 1'b0);
        check_eq("post_reset_ovr", ovr_err, 1'b0);

        // Back-to-back frames with reads
        auto_ack = 1'b1;
        do_tick(1'b1, 1'b0);
        dut_q.delete();
        send_frame(8'h00, 1'b1, 160);
        send_frame(8'hFF, 1'b1, 160);
        send_frame(8'h5A, 1'b1, 160);
        idle(4, 1'b1);
        check_eq("b2b_count", dut_q.size(), 3);
        if (dut_q.size() == 3) begin
            check_eq("b2b_byte0", dut_q[0], 8'h00);
            check_eq("b2b_byte1", dut_q[1], 8'hFF);
            check_eq("b2b_byte2", dut_q[2], 8'h5A);
        end

        // Random frames, gaps, stop bits and read policies
        for (int f = 0; f < 20; f++) begin
            rb          = 8'($urandom_range(0, 255));
            rs          = ($urandom_range(0, 4) != 0);
            gap         = $urandom_range(0, 5);
            auto_ack    = $urandom_range(0, 1);
            ack_on_load = ($urandom_range(0, 3) == 0);
            send_frame(rb, rs, 160);
            idle(gap, 1'b1);
        end
        ack_on_load = 1'b0;
        idle(20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
